// File: rtl/sfc_pkg.sv
// Shared types and helpers for the sample frame collector.
// State codes are plain localparams so they drop into legacy logic [1:0] state registers.
package sfc_pkg;

  localparam int DEF_DATA_W       = 12;
  localparam int DEF_FRAME_LEN    = 8;
  localparam int DEF_SKIP_SAMPLES = 8;

  localparam logic [1:0] FILL = 2'd0;
  localparam logic [1:0] SKIP = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  // Counter width for a count of n; never below one bit so degenerate sizes still elaborate.
  function automatic int idxWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sfc_sat_counter.sv
// Saturating up-counter; holds at all-ones and is cleared only by reset.
module sfc_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sample_frame_collector.sv
// Collects serial ADC samples into double-buffered parallel frames with a skip gap between frames.
// Optional OVERRUN_COUNT_EN adds a 16-bit saturating count of dropped samples on overrun_cnt.
module sample_frame_collector
  import sfc_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int FRAME_LEN    = DEF_FRAME_LEN,
  parameter int SKIP_SAMPLES = DEF_SKIP_SAMPLES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           sample_in,
  input  logic                        sample_valid,
  output logic [FRAME_LEN*DATA_W-1:0] frame_data,
  output logic                        frame_valid,
  input  logic                        frame_ready,
  output logic                        overrun
`ifdef OVERRUN_COUNT_EN
  ,
  output logic [15:0]                 overrun_cnt
`endif
);

  localparam int FW          = FRAME_LEN * DATA_W;
  localparam int IW          = idxWidth(FRAME_LEN);
  localparam int SW          = idxWidth((SKIP_SAMPLES > 0) ? SKIP_SAMPLES : 1);
  localparam int SKIP_LAST_I = (SKIP_SAMPLES > 0) ? SKIP_SAMPLES - 1 : 0;

  localparam logic [IW-1:0] IDX_LAST  = IW'(FRAME_LEN - 1);
  localparam logic [SW-1:0] SKIP_LAST = SW'(SKIP_LAST_I);
  localparam logic [1:0]    POST_LOAD = (SKIP_SAMPLES > 0) ? SKIP : FILL;

  logic [1:0]    state;
  logic [IW-1:0] index;
  logic [SW-1:0] skipCnt;
  logic [FW-1:0] fillBuf;
  logic [FW-1:0] frameData;
  logic          frameValid;
  logic          overrunReg;
  logic          outFree;

  // The output register counts as free when empty or when it is being handed off this very edge.
  assign outFree = !frameValid || frame_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      index      <= '0;
      skipCnt    <= '0;
      fillBuf    <= '0;
      frameData  <= '0;
      frameValid <= 1'b0;
      overrunReg <= 1'b0;
    end else begin
      overrunReg <= 1'b0;
      if (frameValid && frame_ready) begin
        frameValid <= 1'b0;
      end
      case (state)
        FILL: begin
          if (sample_valid) begin
            fillBuf[int'(index)*DATA_W +: DATA_W] <= sample_in;
            if (index == IDX_LAST) begin
              index <= '0;
              if (outFree) begin
                frameData  <= {sample_in, fillBuf[FW-DATA_W-1:0]};
                frameValid <= 1'b1;
                skipCnt    <= '0;
                state      <= POST_LOAD;
              end else begin
                state <= WAIT;
              end
            end else begin
              index <= index + 1'b1;
            end
          end
        end
        WAIT: begin
          if (sample_valid) begin
            overrunReg <= 1'b1;
          end
          if (outFree) begin
            frameData  <= fillBuf;
            frameValid <= 1'b1;
            skipCnt    <= '0;
            index      <= '0;
            state      <= POST_LOAD;
          end
        end
        SKIP: begin
          if (sample_valid) begin
            if (skipCnt == SKIP_LAST) begin
              skipCnt <= '0;
              index   <= '0;
              state   <= FILL;
            end else begin
              skipCnt <= skipCnt + 1'b1;
            end
          end
        end
        default: begin
          state <= FILL;
          index <= '0;
        end
      endcase
    end
  end

  assign frame_data  = frameData;
  assign frame_valid = frameValid;
  assign overrun     = overrunReg;

`ifdef OVERRUN_COUNT_EN
  sfc_sat_counter #(
    .W(16)
  ) overrunCounter (
    .clk  (clk),
    .rst  (rst),
    .inc  (overrunReg),
    .count(overrun_cnt)
  );
`endif

endmodule
